// File: rtl/pulse_width_encoder_pkg.sv
// Shared constants for the pulse-width encoder: the ultrasound period, the
// intensity table size and the pulse-width clamp.
package params;
    localparam int PWE_PERIOD      = 512;
    localparam int PWE_TABLE_DEPTH = 256;

    localparam int TIME_W   = $clog2(PWE_PERIOD);
    localparam int TABLE_AW = $clog2(PWE_TABLE_DEPTH);
    localparam int PW_W     = TIME_W;

    // Widest legal pulse is half a period, which gives 50 % duty.
    localparam logic [PW_W-1:0] PW_MAX = PW_W'(PWE_PERIOD / 2);

    function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] raw);
        return (raw > PW_MAX) ? PW_MAX : raw;
    endfunction
endpackage

// File: rtl/pwe_table.sv
// Intensity-to-pulse-width lookup table: 256x9 simple dual-port RAM with
// synchronous write and a registered, read-first read port.
module pwe_table
    import params::*;
(
    input  logic                CLK,
    input  logic                we,
    input  logic [TABLE_AW-1:0] waddr,
    input  logic [PW_W-1:0]     wdata,
    input  logic [TABLE_AW-1:0] raddr,
    output logic [PW_W-1:0]     rdata
);

    logic [PW_W-1:0] mem [PWE_TABLE_DEPTH];

    // NOTE: neither the array nor the read register is reset, so this maps
    // onto block RAM; the CPU loads every entry before streaming starts.
    // NOTE: non-blocking assignments make the read sample the old entry when
    // the write hits the same address in the same cycle (read-first).
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pulse_width_encoder.sv
// Converts (intensity, phase) beats into rise/fall edge times within one
// ultrasound period, tagging each beat with its transducer index.
module pulse_width_encoder
    import params::*;
#(
    parameter  int DEPTH = 249,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                DIN_VALID,
    input  logic [15:0]         INTENSITY_IN,
    input  logic [7:0]          PHASE_IN,
    input  logic                TABLE_WE,
    input  logic [TABLE_AW-1:0] TABLE_ADDR,
    input  logic [PW_W-1:0]     TABLE_DATA,
    output logic                DOUT_VALID,
    output logic [TIME_W-1:0]   RISE,
    output logic [TIME_W-1:0]   FALL,
    output logic [IDX_W-1:0]    DOUT_IDX,
    output logic                FRAME_DONE
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0]  in_idx;

    logic              s1_valid;
    logic [7:0]        s1_phase;
    logic [IDX_W-1:0]  s1_idx;
    logic [PW_W-1:0]   s1_raw_pw;
    logic [PW_W-1:0]   s1_pw;

    logic              s2_valid;
    logic [PW_W-1:0]   s2_pw;
    logic [PW_W-2:0]   s2_half;
    logic [TIME_W-1:0] s2_centre;
    logic [IDX_W-1:0]  s2_idx;

    // Only the upper intensity byte addresses the table.
    logic unused_intensity_lsbs;
    assign unused_intensity_lsbs = ^INTENSITY_IN[7:0];

    pwe_table u_table (
        .CLK   (CLK),
        .we    (TABLE_WE),
        .waddr (TABLE_ADDR),
        .wdata (TABLE_DATA),
        .raddr (INTENSITY_IN[15:8]),
        .rdata (s1_raw_pw)
    );

    assign s1_pw = clamp_pw(s1_raw_pw);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_idx     <= '0;
            s1_valid   <= 1'b0;
            s1_phase   <= '0;
            s1_idx     <= '0;
            s2_valid   <= 1'b0;
            s2_pw      <= '0;
            s2_half    <= '0;
            s2_centre  <= '0;
            s2_idx     <= '0;
            DOUT_VALID <= 1'b0;
            FRAME_DONE <= 1'b0;
            RISE       <= '0;
            FALL       <= '0;
            DOUT_IDX   <= '0;
        end else begin
            // S1: table read is in flight inside the RAM; phase and index ride alongside.
            s1_valid <= DIN_VALID;
            if (DIN_VALID) begin
                in_idx   <= (in_idx == LAST_IDX) ? '0 : in_idx + 1'b1;
                s1_phase <= PHASE_IN;
                s1_idx   <= in_idx;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_pw     <= s1_pw;
                s2_half   <= s1_pw[PW_W-1:1];
                s2_centre <= {s1_phase, 1'b0};
                s2_idx    <= s1_idx;
            end

            // 9-bit arithmetic wraps modulo the period, which is intended.
            DOUT_VALID <= s2_valid;
            FRAME_DONE <= s2_valid && (s2_idx == LAST_IDX);
            if (s2_valid) begin
                RISE     <= s2_centre - TIME_W'(s2_half);
                FALL     <= s2_centre + s2_pw - TIME_W'(s2_half);
                DOUT_IDX <= s2_idx;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_encoder.sv
// Self-checking bench for pulse_width_encoder: directed beats scored against
// an arithmetic model of the edge-time rules, checked every output cycle.
module tb_pulse_width_encoder;

    localparam int DEPTH = 249;
    localparam int IDX_W = $clog2(DEPTH);

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             DIN_VALID = 1'b0;
    logic [15:0]      INTENSITY_IN = '0;
    logic [7:0]       PHASE_IN = '0;
    logic             TABLE_WE = 1'b0;
    logic [7:0]       TABLE_ADDR = '0;
    logic [8:0]       TABLE_DATA = '0;
    logic             DOUT_VALID;
    logic [8:0]       RISE;
    logic [8:0]       FALL;
    logic [IDX_W-1:0] DOUT_IDX;
    logic             FRAME_DONE;

    pulse_width_encoder #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .DIN_VALID    (DIN_VALID),
        .INTENSITY_IN (INTENSITY_IN),
        .PHASE_IN     (PHASE_IN),
        .TABLE_WE     (TABLE_WE),
        .TABLE_ADDR   (TABLE_ADDR),
        .TABLE_DATA   (TABLE_DATA),
        .DOUT_VALID   (DOUT_VALID),
        .RISE         (RISE),
        .FALL         (FALL),
        .DOUT_IDX     (DOUT_IDX),
        .FRAME_DONE   (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model: table contents as the bench loaded them, plus the edge-time rules.
    int tbl [256];

    function automatic void model_edges(input int inten, input int ph,
                                        output int rise, output int fall);
        int raw;
        int pw;
        int centre;
        raw    = tbl[(inten >> 8) & 255];
        pw     = (raw > 256) ? 256 : raw;
        centre = 2 * ph;
        rise   = (((centre - pw / 2) % 512) + 512) % 512;
        fall   = (centre + pw - pw / 2) % 512;
    endfunction

    typedef struct {
        int rise;
        int fall;
        int idx;
        int edge_n;
    } exp_t;

    exp_t q [$];
    int   model_idx = 0;
    int   edge_cnt = 0;

    always @(posedge CLK) edge_cnt++;

    // Compare process: every output beat must match the oldest expected beat.
    int   last_rise = 0;
    int   last_fall = 0;
    int   last_idx  = 0;
    int   fd_count  = 0;
    exp_t got_e;

    always @(negedge CLK) begin
        if (!RST_N) begin
            last_rise = 0;
            last_fall = 0;
            last_idx  = 0;
        end else if (DOUT_VALID) begin
            if (q.size() == 0) begin
                check("spurious_dout_valid", int'(DOUT_VALID), 0);
            end else begin
                got_e = q.pop_front();
                check("rise", int'(RISE), got_e.rise);
                check("fall", int'(FALL), got_e.fall);
                check("dout_idx", int'(DOUT_IDX), got_e.idx);
                check("latency_edge", edge_cnt, got_e.edge_n);
                check("frame_done", int'(FRAME_DONE), (got_e.idx == DEPTH - 1) ? 1 : 0);
            end
            last_rise = int'(RISE);
            last_fall = int'(FALL);
            last_idx  = int'(DOUT_IDX);
            if (FRAME_DONE) fd_count++;
        end else begin
            check("frame_done_idle", int'(FRAME_DONE), 0);
            check("rise_hold", int'(RISE), last_rise);
            check("fall_hold", int'(FALL), last_fall);
            check("idx_hold", int'(DOUT_IDX), last_idx);
        end
    end

    task automatic push_expected(input int inten, input int ph);
        exp_t e;
        model_edges(inten, ph, e.rise, e.fall);
        e.idx    = model_idx;
        e.edge_n = edge_cnt + 3;
        q.push_back(e);
        model_idx = (model_idx + 1) % DEPTH;
    endtask

    task automatic send_beat(input logic [15:0] inten, input logic [7:0] ph);
        @(negedge CLK);
        DIN_VALID    = 1'b1;
        INTENSITY_IN = inten;
        PHASE_IN     = ph;
        TABLE_WE     = 1'b0;
        push_expected(int'(inten), int'(ph));
    endtask

    task automatic idle();
        @(negedge CLK);
        DIN_VALID = 1'b0;
        TABLE_WE  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge CLK);
        check("drain_queue_empty", q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dout_valid"}, int'(DOUT_VALID), 0);
        check({tag, "_frame_done"}, int'(FRAME_DONE), 0);
        check({tag, "_rise"}, int'(RISE), 0);
        check({tag, "_fall"}, int'(FALL), 0);
        check({tag, "_dout_idx"}, int'(DOUT_IDX), 0);
    endtask

    logic [15:0] vin [5] = '{16'h8000, 16'h8000, 16'h0500, 16'hFFFF, 16'h00FF};
    logic [7:0]  vph [5] = '{8'd64, 8'd0, 8'd10, 8'd255, 8'd100};

    initial begin
        int r;
        int f;

        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RST_N = 1'b1;

        // Table load: identity, then one out-of-range entry for the clamp.
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            TABLE_WE   = 1'b1;
            TABLE_ADDR = 8'(i);
            TABLE_DATA = 9'(i);
            tbl[i]     = i;
        end
        @(negedge CLK);
        TABLE_ADDR = 8'd255;
        TABLE_DATA = 9'd300;
        tbl[255]   = 300;
        idle();

        // Hand-computed values pin the model.
        model_edges(16'h8000, 64, r, f);
        check("model_centre_rise", r, 64);
        check("model_centre_fall", f, 192);
        model_edges(16'h8000, 0, r, f);
        check("model_wrap_rise", r, 448);
        check("model_wrap_fall", f, 64);
        model_edges(16'h0500, 10, r, f);
        check("model_odd_rise", r, 18);
        check("model_odd_fall", f, 23);
        model_edges(16'hFFFF, 255, r, f);
        check("model_clamp_rise", r, 382);
        check("model_clamp_fall", f, 126);
        model_edges(16'h00FF, 100, r, f);
        check("model_zero_rise", r, 200);
        check("model_zero_fall", f, 200);

        // Centre case: one full contiguous frame.
        fd_count = 0;
        for (int i = 0; i < DEPTH; i++) send_beat(16'h8000, 8'd64);
        idle();
        drain();
        check("centre_frame_done_pulses", fd_count, 1);

        // Mixed vectors: wrap, odd width, clamp, zero width.
        for (int i = 0; i < DEPTH; i++) send_beat(vin[i % 5], vph[i % 5]);
        idle();
        drain();

        // Gapped stream over two frames: one idle cycle after every 7 beats.
        fd_count = 0;
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < DEPTH; i++) begin
                send_beat(vin[(i + fr) % 5], 8'((i * 37 + fr) % 256));
                if (i % 7 == 6) idle();
            end
        end
        idle();
        drain();
        check("gapped_frame_done_pulses", fd_count, 2);

        // Reset mid-frame after 100 beats.
        for (int i = 0; i < 100; i++) send_beat(vin[i % 5], vph[(i + 2) % 5]);
        idle();
        #2 RST_N = 1'b0;
        #1 check_outputs_zero("midframe_reset");
        q.delete();
        model_idx = 0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        fd_count = 0;
        for (int i = 0; i < DEPTH; i++) send_beat(vin[(i + 3) % 5], vph[i % 5]);
        idle();
        drain();
        check("post_reset_frame_done_pulses", fd_count, 1);

        // Table write colliding with a read of the same entry.
        @(negedge CLK);
        DIN_VALID    = 1'b1;
        INTENSITY_IN = 16'h8033;
        PHASE_IN     = 8'd64;
        TABLE_WE     = 1'b1;
        TABLE_ADDR   = 8'h80;
        TABLE_DATA   = 9'd10;
        push_expected(16'h8033, 64);
        tbl[128] = 10;
        send_beat(16'h8000, 8'd64);
        idle();
        model_edges(16'h8000, 64, r, f);
        check("model_newentry_rise", r, 123);
        check("model_newentry_fall", f, 133);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
